// File: rtl/almacen_pkg.sv
// Shared definitions for the storage-lane controller: lane state encoding
// and default sizing constants.
package almacen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_RUN  = 2'd1,
        OUT_RUN = 2'd2,
        FAULT   = 2'd3
    } lane_state_t;

    localparam int N_LANES_DEF     = 4;
    localparam int CAPACITY_DEF    = 8;
    localparam int CNT_W_DEF       = 4;
    localparam int DEB_CYC_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 1000;

endpackage

// File: rtl/almacen_lane.sv
// One storage lane: two sensor debouncers, the entry/exit FSM, its run
// timeout and the saturating stock counter.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | waiting for a single filtered sensor, actuators off
// IN_RUN  | entry actuator on, waiting for both sensors low
// OUT_RUN | exit actuator on, waiting for both sensors low
// FAULT   | run timed out, waits for fault_clr with sensors low
module almacen_lane
    import almacen_pkg::*;
#(
    parameter int CAPACITY    = CAPACITY_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEB_CYC     = DEB_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1,
    input  logic             s2,
    input  logic             fault_clr,
    output logic             a,
    output logic             c,
    output logic [CNT_W-1:0] stock,
    output logic             full,
    output logic             empty,
    output logic             fault
);

    localparam int DEB_W = $clog2(DEB_CYC + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

    logic [1:0]       raw;
    logic [1:0]       filt;
    logic [DEB_W-1:0] deb_cnt [2];
    logic             s1f, s2f, quiet;

    lane_state_t      state;
    logic [TMR_W-1:0] timer;

    assign raw   = {s2, s1};
    assign s1f   = filt[0];
    assign s2f   = filt[1];
    assign quiet = !s1f && !s2f;
    assign full  = (stock == CAP);
    assign empty = (stock == '0);

    // Filtered value follows raw only after DEB_CYC consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt       <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] != filt[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        filt[i]    <= raw[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Timer is a down-counter loaded on run entry; reaching zero without the
    // exit condition means the run lasted TIMEOUT_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            stock <= '0;
            a     <= 1'b0;
            c     <= 1'b0;
            fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s1f && !s2f && !full) begin
                        state <= IN_RUN;
                        timer <= TMR_LOAD;
                        a     <= 1'b1;
                    end else if (s2f && !s1f && !empty) begin
                        state <= OUT_RUN;
                        timer <= TMR_LOAD;
                        c     <= 1'b1;
                    end
                end
                IN_RUN: begin
                    if (quiet) begin
                        state <= IDLE;
                        a     <= 1'b0;
                        if (stock != CAP) stock <= stock + CNT_W'(1);
                    end else if (timer == '0) begin
                        state <= FAULT;
                        a     <= 1'b0;
                        fault <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                OUT_RUN: begin
                    if (quiet) begin
                        state <= IDLE;
                        c     <= 1'b0;
                        if (stock != '0) stock <= stock - CNT_W'(1);
                    end else if (timer == '0) begin
                        state <= FAULT;
                        c     <= 1'b0;
                        fault <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                FAULT: begin
                    if (fault_clr && quiet) begin
                        state <= IDLE;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    a     <= 1'b0;
                    c     <= 1'b0;
                    fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/almacen_ctrl.sv
// Multi-lane storage controller: N_LANES independent lane instances with
// their stock counts packed side by side on one bus.
module almacen_ctrl
    import almacen_pkg::*;
#(
    parameter int N_LANES     = N_LANES_DEF,
    parameter int CAPACITY    = CAPACITY_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEB_CYC     = DEB_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_LANES-1:0]         s1,
    input  logic [N_LANES-1:0]         s2,
    input  logic [N_LANES-1:0]         fault_clr,
    output logic [N_LANES-1:0]         a,
    output logic [N_LANES-1:0]         c,
    output logic [N_LANES*CNT_W-1:0]   stock,
    output logic [N_LANES-1:0]         full,
    output logic [N_LANES-1:0]         empty,
    output logic [N_LANES-1:0]         fault
);

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        almacen_lane #(
            .CAPACITY    (CAPACITY),
            .CNT_W       (CNT_W),
            .DEB_CYC     (DEB_CYC),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .s1        (s1[i]),
            .s2        (s2[i]),
            .fault_clr (fault_clr[i]),
            .a         (a[i]),
            .c         (c[i]),
            .stock     (stock[i*CNT_W +: CNT_W]),
            .full      (full[i]),
            .empty     (empty[i]),
            .fault     (fault[i])
        );
    end

endmodule

// File: tb/tb_almacen_ctrl.sv
// Directed bench for almacen_ctrl with two small lanes (capacity 2,
// 4-cycle debounce, 20-cycle run timeout).
module tb_almacen_ctrl;

    localparam int N_LANES = 2;
    localparam int CNT_W   = 4;

    logic                     clk;
    logic                     rst_n;
    logic [N_LANES-1:0]       s1, s2, fault_clr;
    logic [N_LANES-1:0]       a, c, full, empty, fault;
    logic [N_LANES*CNT_W-1:0] stock;

    int errors = 0;
    int checks = 0;

    almacen_ctrl #(
        .N_LANES     (N_LANES),
        .CAPACITY    (2),
        .CNT_W       (CNT_W),
        .DEB_CYC     (4),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s1        (s1),
        .s2        (s2),
        .fault_clr (fault_clr),
        .a         (a),
        .c         (c),
        .stock     (stock),
        .full      (full),
        .empty     (empty),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        s1 = '0; s2 = '0; fault_clr = '0;
        rst_n = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(1);
    endtask

    task automatic entry_cycle(input int lane);
        s1[lane] = 1'b1;
        wait_neg(10);
        s1[lane] = 1'b0;
        wait_neg(6);
    endtask

    task automatic test_reset();
        s1 = '0; s2 = '0; fault_clr = '0;
        rst_n = 1'b0;
        wait_neg(2);
        checks++;
        if ({a, c, full, fault} !== 8'h00 || stock !== 8'h00 || empty !== 2'b11) begin
            errors++;
            $display("FAIL reset: a=%b c=%b full=%b fault=%b stock=%h empty=%b exp all 0, empty=11",
                     a, c, full, fault, stock, empty);
        end
        rst_n = 1'b1;
        wait_neg(1);
    endtask

    task automatic test_entry();
        do_reset();
        s1[0] = 1'b1;
        wait_neg(4);
        checks++;
        if (a[0] !== 1'b0) begin errors++; $display("FAIL entry_a_early: a0=%b exp 0", a[0]); end
        wait_neg(1);
        checks++;
        if (a[0] !== 1'b1) begin errors++; $display("FAIL entry_a_on: a0=%b exp 1", a[0]); end
        wait_neg(5);
        s1[0] = 1'b0;
        wait_neg(4);
        checks++;
        if (a[0] !== 1'b1 || stock[3:0] !== 4'd0) begin
            errors++; $display("FAIL entry_hold: a0=%b stock0=%0d exp 1,0", a[0], stock[3:0]);
        end
        wait_neg(1);
        checks++;
        if (a[0] !== 1'b0 || stock[3:0] !== 4'd1 || empty[0] !== 1'b0) begin
            errors++; $display("FAIL entry_done: a0=%b stock0=%0d empty0=%b exp 0,1,0", a[0], stock[3:0], empty[0]);
        end
        checks++;
        if (a[1] !== 1'b0 || c[1] !== 1'b0 || stock[7:4] !== 4'd0 || empty[1] !== 1'b1) begin
            errors++; $display("FAIL lane1_untouched: a1=%b c1=%b stock1=%0d empty1=%b exp 0,0,0,1",
                               a[1], c[1], stock[7:4], empty[1]);
        end
    endtask

    task automatic test_fill();
        entry_cycle(0);
        checks++;
        if (stock[3:0] !== 4'd2 || full[0] !== 1'b1) begin
            errors++; $display("FAIL fill_full: stock0=%0d full0=%b exp 2,1", stock[3:0], full[0]);
        end
        s1[0] = 1'b1;
        wait_neg(7);
        checks++;
        if (a[0] !== 1'b0) begin errors++; $display("FAIL fill_blocked: a0=%b exp 0", a[0]); end
        s1[0] = 1'b0;
        wait_neg(6);
        checks++;
        if (stock[3:0] !== 4'd2 || full[0] !== 1'b1) begin
            errors++; $display("FAIL fill_sat: stock0=%0d full0=%b exp 2,1", stock[3:0], full[0]);
        end
    endtask

    task automatic test_exit();
        s2[1] = 1'b1;
        wait_neg(8);
        checks++;
        if (c[1] !== 1'b0) begin errors++; $display("FAIL exit_empty_block: c1=%b exp 0", c[1]); end
        s2[1] = 1'b0;
        wait_neg(6);
        entry_cycle(1);
        checks++;
        if (stock[7:4] !== 4'd1 || empty[1] !== 1'b0) begin
            errors++; $display("FAIL exit_prefill: stock1=%0d empty1=%b exp 1,0", stock[7:4], empty[1]);
        end
        s2[1] = 1'b1;
        wait_neg(5);
        checks++;
        if (c[1] !== 1'b1) begin errors++; $display("FAIL exit_c_on: c1=%b exp 1", c[1]); end
        wait_neg(3);
        s2[1] = 1'b0;
        wait_neg(6);
        checks++;
        if (c[1] !== 1'b0 || stock[7:4] !== 4'd0 || empty[1] !== 1'b1) begin
            errors++; $display("FAIL exit_done: c1=%b stock1=%0d empty1=%b exp 0,0,1", c[1], stock[7:4], empty[1]);
        end
        checks++;
        if (stock[3:0] !== 4'd2) begin errors++; $display("FAIL exit_lane0_kept: stock0=%0d exp 2", stock[3:0]); end
    endtask

    task automatic test_timeout();
        do_reset();
        s1[0] = 1'b1;
        wait_neg(24);
        checks++;
        if (a[0] !== 1'b1 || fault[0] !== 1'b0) begin
            errors++; $display("FAIL timeout_last_run: a0=%b fault0=%b exp 1,0", a[0], fault[0]);
        end
        wait_neg(1);
        checks++;
        if (a[0] !== 1'b0 || fault[0] !== 1'b1 || stock[3:0] !== 4'd0) begin
            errors++; $display("FAIL timeout_fault: a0=%b fault0=%b stock0=%0d exp 0,1,0", a[0], fault[0], stock[3:0]);
        end
        wait_neg(5);
        fault_clr[0] = 1'b1;
        wait_neg(3);
        checks++;
        if (fault[0] !== 1'b1) begin errors++; $display("FAIL timeout_clr_blocked: fault0=%b exp 1", fault[0]); end
        fault_clr[0] = 1'b0;
        s1[0] = 1'b0;
        wait_neg(5);
        checks++;
        if (fault[0] !== 1'b1) begin errors++; $display("FAIL timeout_no_clr: fault0=%b exp 1", fault[0]); end
        fault_clr[0] = 1'b1;
        wait_neg(1);
        fault_clr[0] = 1'b0;
        checks++;
        if (fault[0] !== 1'b0 || a[0] !== 1'b0 || stock[3:0] !== 4'd0) begin
            errors++; $display("FAIL timeout_cleared: fault0=%b a0=%b stock0=%0d exp 0,0,0", fault[0], a[0], stock[3:0]);
        end
    endtask

    task automatic test_glitch_conflict();
        do_reset();
        s1[0] = 1'b1;
        wait_neg(3);
        s1[0] = 1'b0;
        wait_neg(8);
        checks++;
        if (a[0] !== 1'b0 || stock[3:0] !== 4'd0) begin
            errors++; $display("FAIL glitch: a0=%b stock0=%0d exp 0,0", a[0], stock[3:0]);
        end
        s1[0] = 1'b1; s2[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_neg(1);
            checks++;
            if (a[0] !== 1'b0 || c[0] !== 1'b0) begin
                errors++; $display("FAIL conflict_cyc%0d: a0=%b c0=%b exp 0,0", i, a[0], c[0]);
            end
        end
        s1[0] = 1'b0; s2[0] = 1'b0;
        wait_neg(6);
        checks++;
        if (stock[3:0] !== 4'd0 || empty[0] !== 1'b1 || a[0] !== 1'b0) begin
            errors++; $display("FAIL conflict_after: stock0=%0d empty0=%b a0=%b exp 0,1,0", stock[3:0], empty[0], a[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        entry_cycle(0);
        s1[0] = 1'b1;
        wait_neg(6);
        checks++;
        if (a[0] !== 1'b1 || stock[3:0] !== 4'd1) begin
            errors++; $display("FAIL midrst_pre: a0=%b stock0=%0d exp 1,1", a[0], stock[3:0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (a[0] !== 1'b0 || stock[3:0] !== 4'd0 || empty[0] !== 1'b1) begin
            errors++; $display("FAIL midrst_abort: a0=%b stock0=%0d empty0=%b exp 0,0,1", a[0], stock[3:0], empty[0]);
        end
        s1[0] = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        s1[0] = 1'b1;
        wait_neg(5);
        checks++;
        if (a[0] !== 1'b1) begin errors++; $display("FAIL midrst_resume: a0=%b exp 1", a[0]); end
        s1[0] = 1'b0;
        wait_neg(6);
    endtask

    initial begin
        test_reset();
        test_entry();
        test_fill();
        test_exit();
        test_timeout();
        test_glitch_conflict();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
